// File: rtl/shifter_pkg.sv
// Shared mode encodings and level-to-stage mapping for the pipelined shifter.
package shifter_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // Mux level 'level' (shift by 2**level) lives in this pipeline stage.
  function automatic int stage_of_level(input int level, input int stages, input int distw);
    return (level * stages) / distw;
  endfunction

endpackage

// File: rtl/shift_level.sv
// One mux level of the shifter: conditionally shifts/rotates by a fixed AMOUNT.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int AMOUNT = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_enable,
  input  logic [2:0]       i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_enable) begin
      case (i_mode)
        MODE_SLL: o_data = {i_data[WIDTH-AMOUNT-1:0], {AMOUNT{1'b0}}};
        MODE_SRL: o_data = {{AMOUNT{1'b0}}, i_data[WIDTH-1:AMOUNT]};
        // Sign comes from the original operand so every level fills consistently.
        MODE_SRA: o_data = {{AMOUNT{i_sign}}, i_data[WIDTH-1:AMOUNT]};
        MODE_ROL: o_data = {i_data[WIDTH-AMOUNT-1:0], i_data[WIDTH-1:WIDTH-AMOUNT]};
        MODE_ROR: o_data = {i_data[AMOUNT-1:0], i_data[WIDTH-1:AMOUNT]};
        default:  o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shift/rotate unit: log2(WIDTH) mux levels spread over STAGES registered
// stages, with a tag riding alongside, valid/ready backpressure and flush.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAGW   = 5,
  localparam int DISTW  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DISTW-1:0] in_dist,
  input  logic [2:0]       in_mode,
  input  logic [TAGW-1:0]  in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag
);

  logic                          w_advance;
  logic [STAGES-1:0]             r_valid;
  logic [STAGES-1:0][WIDTH-1:0]  r_data;
  logic [STAGES-1:0][DISTW-1:0]  r_dist;
  logic [STAGES-1:0][2:0]        r_mode;
  logic [STAGES-1:0]             r_sign;
  logic [STAGES-1:0][TAGW-1:0]   r_tag;
  logic [WIDTH-1:0]              w_lvl [DISTW];
  logic [WIDTH-1:0]              w_stage_res [STAGES];
  logic                          w_unused;

  // The whole pipe moves in lockstep; bubbles are held, not squeezed out.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];

  // Control fields of the last stage and of already-consumed distance bits go nowhere.
  assign w_unused = ^{r_dist, r_mode, r_sign};

  genvar gi;
  generate
    for (gi = 0; gi < DISTW; gi++) begin : g_level
      localparam int STG   = stage_of_level(gi, STAGES, DISTW);
      localparam bit FIRST = (gi == 0) || (stage_of_level(gi - 1, STAGES, DISTW) != STG);
      localparam bit LAST  = (gi == DISTW - 1) || (stage_of_level(gi + 1, STAGES, DISTW) != STG);

      logic [WIDTH-1:0] w_src;
      logic             w_en;
      logic [2:0]       w_mode;
      logic             w_sign;

      if (STG == 0) begin : g_ctl_in
        assign w_en   = in_dist[gi];
        assign w_mode = in_mode;
        assign w_sign = in_data[WIDTH-1];
      end else begin : g_ctl_reg
        assign w_en   = r_dist[STG-1][gi];
        assign w_mode = r_mode[STG-1];
        assign w_sign = r_sign[STG-1];
      end

      if (!FIRST) begin : g_src_chain
        assign w_src = w_lvl[gi-1];
      end else if (STG == 0) begin : g_src_in
        assign w_src = in_data;
      end else begin : g_src_reg
        assign w_src = r_data[STG-1];
      end

      shift_level #(
        .WIDTH  (WIDTH),
        .AMOUNT (1 << gi)
      ) u_level (
        .i_data   (w_src),
        .i_enable (w_en),
        .i_mode   (w_mode),
        .i_sign   (w_sign),
        .o_data   (w_lvl[gi])
      );

      if (LAST) begin : g_stage_end
        assign w_stage_res[STG] = w_lvl[gi];
      end
    end
  endgenerate

  // Flush and reset beat a stall: valid bits drop even when nothing advances.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid <= '0;
    end else if (w_advance) begin
      r_valid[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_advance) begin
      r_data[0] <= w_stage_res[0];
      r_dist[0] <= in_dist;
      r_mode[0] <= in_mode;
      r_sign[0] <= in_data[WIDTH-1];
      r_tag[0]  <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s] <= w_stage_res[s];
        r_dist[s] <= r_dist[s-1];
        r_mode[s] <= r_mode[s-1];
        r_sign[s] <= r_sign[s-1];
        r_tag[s]  <= r_tag[s-1];
      end
    end
  end

endmodule
